mod3_seq_ctrl: RTL and testbench

MOD3_SEQ_CTRL -- requirements
Module: mod3_seq_ctrl

---
 rtl/mod3_pkg.sv | 13 +
 rtl/mod3_fsm_core.sv | 18 +
 rtl/mod3_seq_ctrl.sv | 99 +++++++++
 tb/tb_mod3_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod3_pkg.sv
// mod3_pkg: shared state encoding, remainder constants and the mod-3 fold step.
package mod3_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [1:0] REM0 = 2'd0;
   localparam logic [1:0] REM1 = 2'd1;
   localparam logic [1:0] REM2 = 2'd2;
   // (2*r + b) mod 3 as a lookup, so the encoding 3 can never be produced.
   function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
      return (r == REM0) ? (b ? REM1 : REM0) :
             (r == REM1) ? (b ? REM0 : REM2) :
                           (b ? REM2 : REM1);
   endfunction
endpackage

// File: rtl/mod3_fsm_core.sv
// mod3_fsm_core: 2-bit running remainder register folded one bit per step.
module mod3_fsm_core
   import mod3_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       step_i,
   input  logic       bit_i,
   output logic [1:0] rem_o
);
   logic [1:0] rem_q, rem_d;
   always_comb rem_d = clr_i ? REM0 : step_i ? mod3_step(rem_q, bit_i) : rem_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) rem_q <= REM0;
      else     rem_q <= rem_d;
   assign rem_o = rem_q;
endmodule

// File: rtl/mod3_seq_ctrl.sv
// mod3_seq_ctrl: serial MSB-first divisibility-by-3 tester with
// valid/ready handshakes, a clock-enable bit-step divider and flush.
module mod3_seq_ctrl
   import mod3_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_rem,
   output logic             out_div3,
   output logic             busy,
   output logic             tick
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    div_q, div_d;
   logic [1:0]       out_rem_q, out_rem_d, rem, rem_fin;
   logic             out_div3_q, out_div3_d, clr, step;
   mod3_fsm_core u_core (
      .clk    (clk),
      .rst    (reset),
      .clr_i  (clr),
      .step_i (step),
      .bit_i  (sr_q[WIDTH-1]),
      .rem_o  (rem)
   );
   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == SHIFT);
   assign out_valid = (state_q == DONE);
   assign tick      = busy && (div_q == DW'(DIV - 1));
   assign out_rem   = out_rem_q;
   assign out_div3  = out_div3_q;
   // Final bit folded directly into the output register on the last tick.
   assign rem_fin   = mod3_step(rem, sr_q[WIDTH-1]);
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      out_rem_d  = out_rem_q;
      out_div3_d = out_div3_q;
      clr        = 1'b0;
      step       = 1'b0;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = SHIFT;
            sr_d    = in_data;
            cnt_d   = CW'(WIDTH);
            div_d   = '0;
            clr     = 1'b1;
         end
         SHIFT: if (flush) begin
            state_d = IDLE;
            div_d   = '0;
         end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
               step  = 1'b1;
               sr_d  = sr_q << 1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_d    = DONE;
                  out_rem_d  = rem_fin;
                  out_div3_d = (rem_fin == REM0);
               end
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         div_q      <= '0;
         out_rem_q  <= REM0;
         out_div3_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         out_rem_q  <= out_rem_d;
         out_div3_q <= out_div3_d;
      end
endmodule

// File: tb/tb_mod3_seq_ctrl.sv
// tb_mod3_seq_ctrl: directed vectors plus corner sequences for mod3_seq_ctrl.
module tb_mod3_seq_ctrl;
   logic       clk = 1'b0, reset = 1'b1;
   logic       in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, out_valid, out_div3, busy, tick;
   logic [1:0] out_rem;
   logic       b_in_valid = 1'b0, b_flush = 1'b0, b_out_ready = 1'b0;
   logic [7:0] b_in_data = '0;
   logic       b_in_ready, b_out_valid, b_out_div3, b_busy, b_tick;
   logic [1:0] b_out_rem;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   mod3_seq_ctrl #(.WIDTH(8), .DIV(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_rem(out_rem), .out_div3(out_div3),
      .busy(busy), .tick(tick)
   );
   mod3_seq_ctrl #(.WIDTH(8), .DIV(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_ready(b_in_ready), .flush(b_flush), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_rem(b_out_rem), .out_div3(b_out_div3),
      .busy(b_busy), .tick(b_tick)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] rem;
      logic       div3;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [7:0] d, output int lat, output int ticks,
                         output int busys, output int cad_bad);
      lat = 0; ticks = 0; busys = 0; cad_bad = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1 in_valid = 1'b0;
      while (lat < 100 && !out_valid) begin
         @(negedge clk);
         if (busy) busys++;
         if (tick) begin
            ticks++;
            if (lat % 4 != 3) cad_bad++;
         end
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("hs_valid_low", out_valid, 0);
      chk("hs_ready_high", in_ready, 1);
   endtask

   initial begin
      int lat, ticks, busys, cad, cnt, cyc, acc1, acc2;
      vecs[0] = '{8'd9,   2'd0, 1'b1};
      vecs[1] = '{8'd200, 2'd2, 1'b0};
      vecs[2] = '{8'd255, 2'd0, 1'b1};
      vecs[3] = '{8'd1,   2'd1, 1'b0};
      vecs[4] = '{8'd0,   2'd0, 1'b1};
      vecs[5] = '{8'd128, 2'd2, 1'b0};
      vecs[6] = '{8'd100, 2'd1, 1'b0};
      vecs[7] = '{8'd170, 2'd2, 1'b0};

      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rem", out_rem, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tick", tick, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_op(vecs[i].data, lat, ticks, busys, cad);
         chk($sformatf("lat_%0d", vecs[i].data), lat, 32);
         chk($sformatf("rem_%0d", vecs[i].data), out_rem, vecs[i].rem);
         chk($sformatf("div3_%0d", vecs[i].data), out_div3, vecs[i].div3);
         chk("tick_count", ticks, 8);
         chk("busy_cycles", busys, 32);
         chk("tick_cadence", cad, 0);
         handshake();
      end

      // backpressure with in_valid pressing in DONE
      run_op(8'd200, lat, ticks, busys, cad);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'd9;
         chk("bp_valid", out_valid, 1);
         chk("bp_rem", out_rem, 2);
         chk("bp_div3", out_div3, 0);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      in_valid = 1'b0;
      chk("bp_no_accept_busy", busy, 0);
      chk("bp_idle_ready", in_ready, 1);
      chk("bp_valid_low", out_valid, 0);

      // flush mid-SHIFT
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd200;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_ready", in_ready, 1);
      chk("flush_busy", busy, 0);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid || busy) cnt++;
      end
      chk("flush_no_output", cnt, 0);
      run_op(8'd9, lat, ticks, busys, cad);
      chk("post_flush_lat", lat, 32);
      chk("post_flush_rem", out_rem, 0);
      handshake();

      // flush in IDLE is ignored
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("idle_flush_ready", in_ready, 1);

      // async reset mid-SHIFT
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd200;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_tick", tick, 0);
      chk("arst_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      run_op(8'd5, lat, ticks, busys, cad);
      chk("post_rst_lat", lat, 32);
      chk("post_rst_rem", out_rem, 2);

      // async reset in DONE
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_done_valid", out_valid, 0);
      chk("arst_done_rem", out_rem, 0);
      chk("arst_done_div3", out_div3, 0);
      @(negedge clk);
      reset = 1'b0;

      // back-to-back with in_valid and out_ready held high
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'd255;
      out_ready = 1'b1;
      cyc = 0; acc1 = -1; acc2 = -1;
      while (cyc < 200 && acc2 < 0) begin
         if (in_ready) begin
            if (acc1 < 0) acc1 = cyc;
            else acc2 = cyc;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("b2b_spacing", acc2 - acc1, 34);
      repeat (40) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_drained", in_ready, 1);

      // DIV=1 build
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = 8'd200;
      @(posedge clk);
      #1 b_in_valid = 1'b0;
      lat = 0; ticks = 0;
      while (lat < 100 && !b_out_valid) begin
         @(negedge clk);
         if (b_tick) ticks++;
         @(posedge clk);
         #1 lat++;
      end
      chk("div1_lat", lat, 8);
      chk("div1_ticks", ticks, 8);
      chk("div1_rem", b_out_rem, 2);
      chk("div1_div3", b_out_div3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
